// File: rtl/slowclk_scheduler_if.sv
// Configuration write port for slowclk_scheduler: valid/ready transfer of one
// channel's divisor and enable.
interface slowclk_scheduler_if #(
  parameter int DIV_W = 16
) ();
  logic             valid;
  logic             ready;
  logic [1:0]       ch;
  logic [DIV_W-1:0] div;
  logic             en;

  modport master (output valid, ch, div, en, input ready);
  modport slave  (input valid, ch, div, en, output ready);
endinterface

// File: rtl/slowclk_scheduler.sv
// Four-channel clock-enable scheduler: one shared prescaler feeds per-channel
// divisors that produce a one-cycle tick and a 50 % duty slow square wave.
//
//   state | meaning
//   IDLE  | cfg.ready high; a write latches div/en and moves to APPLY
//   APPLY | one cycle; clears the written channel's counter and suppresses its tick
module slowclk_scheduler #(
  parameter int PRESCALE = 100000,
  parameter int DIV_W    = 16
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  slowclk_scheduler_if.slave cfg,
  input  logic               sync_start,
  output logic [3:0]         tick,
  output logic [3:0]         slowclk
);
  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic {IDLE, APPLY} state_t;

  state_t                  state, state_nxt;
  logic                    ready;
  logic                    xfer;
  logic [PS_W-1:0]         pre;
  logic                    base;
  logic [3:0][DIV_W-1:0]   div;
  logic [3:0]              en;
  logic [1:0]              apply_ch;

  assign cfg.ready = ready;
  assign xfer      = cfg.valid && ready;
  assign base      = (pre == PS_LAST);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (cfg.valid) state_nxt = APPLY;
      end
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)        pre <= '0;
    else if (sync_start) pre <= '0;
    else if (base)       pre <= '0;
    else                 pre <= pre + PS_W'(1);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      div      <= '0;
      en       <= '0;
      apply_ch <= '0;
    end else if (xfer) begin
      div[cfg.ch] <= cfg.div;
      en[cfg.ch]  <= cfg.en;
      apply_ch    <= cfg.ch;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;
    logic             tick_q;
    logic             slow_q;
    logic             apply_hit;

    // A divisor of 0 behaves as 1, so the compare value never underflows.
    assign last      = (div[g] == '0) ? '0 : div[g] - DIV_W'(1);
    assign apply_hit = (state == APPLY) && (apply_ch == 2'(g));

    always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
        cnt    <= '0;
        tick_q <= 1'b0;
        slow_q <= 1'b0;
      end else if (sync_start) begin
        cnt    <= '0;
        tick_q <= 1'b0;
        slow_q <= 1'b0;
      end else if (apply_hit) begin
        cnt    <= '0;
        tick_q <= 1'b0;
        if (!en[g]) slow_q <= 1'b0;
      end else if (!en[g]) begin
        cnt    <= '0;
        tick_q <= 1'b0;
        slow_q <= 1'b0;
      end else if (base) begin
        if (cnt == last) begin
          cnt    <= '0;
          tick_q <= 1'b1;
          slow_q <= ~slow_q;
        end else begin
          cnt    <= cnt + DIV_W'(1);
          tick_q <= 1'b0;
        end
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign tick[g]    = tick_q;
    assign slowclk[g] = slow_q;
  end
endmodule

// File: tb/tb_slowclk_scheduler.sv
// Directed bench for slowclk_scheduler with PRESCALE = 4; expected cycle
// distances are hand-derived from the prescaler and divisor values.
module tb_slowclk_scheduler;
  localparam int PRESCALE = 4;
  localparam int DIV_W    = 16;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       sync_start = 1'b0;
  logic [3:0] tick;
  logic [3:0] slowclk;
  int         cyc        = 0;
  int         n_checks   = 0;
  int         n_errors   = 0;

  slowclk_scheduler_if #(.DIV_W(DIV_W)) cfg_if ();

  slowclk_scheduler #(.PRESCALE(PRESCALE), .DIV_W(DIV_W)) dut (
    .CLOCK      (clk),
    .RESET_N    (rst_n),
    .cfg        (cfg_if),
    .sync_start (sync_start),
    .tick       (tick),
    .slowclk    (slowclk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called just after a negedge; returns just after the negedge where ready is back.
  task automatic cfg_write(input int ch, input int dv, input int en);
    cfg_if.ch    = 2'(ch);
    cfg_if.div   = DIV_W'(dv);
    cfg_if.en    = en[0];
    cfg_if.valid = 1'b1;
    check_eq("wr_ready_pre", int'(cfg_if.ready), 1);
    @(negedge clk);
    cfg_if.valid = 1'b0;
    check_eq("wr_apply_busy", int'(cfg_if.ready), 0);
    @(negedge clk);
    check_eq("wr_ready_back", int'(cfg_if.ready), 1);
  endtask

  task automatic wait_tick(input int ch, input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit && at < 0; k++) begin
      @(negedge clk);
      if (tick[ch]) at = cyc;
    end
  endtask

  task automatic wait_rise(input int ch, input int limit, output int at);
    logic prev;
    prev = slowclk[ch];
    at   = -1;
    for (int k = 0; k < limit && at < 0; k++) begin
      @(negedge clk);
      if (slowclk[ch] && !prev) at = cyc;
      prev = slowclk[ch];
    end
  endtask

  initial begin
    int t_a, t_b, s0, f0, f1, f2, fc, n_t, nxt, t0, t2, t2n;
    int divs [4];
    divs = '{3, 1, 5, 2};
    cfg_if.valid = 1'b0;
    cfg_if.ch    = '0;
    cfg_if.div   = '0;
    cfg_if.en    = 1'b0;

    // reset and idle
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tick", int'(tick), 0);
    check_eq("rst_slow", int'(slowclk), 0);
    check_eq("rst_ready", int'(cfg_if.ready), 1);
    rst_n = 1'b1;
    n_t = 0;
    repeat (100) begin
      @(negedge clk);
      if (tick != 4'b0) n_t++;
    end
    check_eq("idle_no_tick", n_t, 0);

    // ch0 div 3
    cfg_write(0, 3, 1);
    wait_tick(0, 40, t_a);
    @(negedge clk);
    check_eq("tick0_width", int'(tick[0]), 0);
    wait_tick(0, 40, t_b);
    check_eq("tick0_period", t_b - t_a, 12);
    wait_rise(0, 60, t_a);
    wait_rise(0, 60, t_b);
    check_eq("slow0_period", t_b - t_a, 24);

    // ch1 div 0 behaves as 1
    cfg_write(1, 0, 1);
    wait_tick(1, 20, t_a);
    wait_tick(1, 20, t_b);
    check_eq("tick1_period", t_b - t_a, 4);

    // staggered ch2/ch0 writes, then realign
    cfg_write(2, 5, 1);
    repeat (5) @(negedge clk);
    cfg_write(0, 3, 1);
    repeat (3) @(negedge clk);
    sync_start = 1'b1;
    @(negedge clk);
    sync_start = 1'b0;
    s0 = cyc;
    check_eq("sync_slow", int'(slowclk), 0);
    check_eq("sync_tick", int'(tick), 0);
    f0 = -1; f1 = -1; f2 = -1; fc = -1;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (tick[0] && f0 < 0) begin
        f0 = cyc;
        check_eq("sync_slow0_up", int'(slowclk[0]), 1);
      end
      if (tick[1] && f1 < 0) f1 = cyc;
      if (tick[2] && f2 < 0) f2 = cyc;
      if (tick[0] && tick[2] && fc < 0) fc = cyc;
    end
    check_eq("sync_first0", f0 - s0, 12);
    check_eq("sync_first1", f1 - s0, 4);
    check_eq("sync_first2", f2 - s0, 20);
    check_eq("sync_common", fc - s0, 60);

    // back-to-back writes with valid held high
    nxt = 0;
    cfg_if.valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (nxt < 4) begin
        cfg_if.ch  = 2'(nxt);
        cfg_if.div = DIV_W'(divs[nxt]);
        cfg_if.en  = 1'b1;
      end else begin
        cfg_if.valid = 1'b0;
      end
      check_eq("burst_ready", int'(cfg_if.ready), (k % 2 == 0) ? 1 : 0);
      if (cfg_if.ready && cfg_if.valid) nxt++;
      @(negedge clk);
    end
    cfg_if.valid = 1'b0;
    check_eq("burst_count", nxt, 4);
    wait_tick(3, 30, t_a);
    wait_tick(3, 30, t_b);
    check_eq("tick3_period", t_b - t_a, 8);
    wait_tick(0, 40, t_a);
    wait_tick(0, 40, t_b);
    check_eq("burst_tick0_period", t_b - t_a, 12);

    // disable ch0 mid-period; ch2 phase must hold
    wait_tick(2, 40, t2);
    wait_tick(0, 40, t0);
    repeat (3) @(negedge clk);
    cfg_write(0, 3, 0);
    check_eq("dis_slow0", int'(slowclk[0]), 0);
    n_t = 0; t2n = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tick[0]) n_t++;
      if (tick[2] && t2n < 0) t2n = cyc;
    end
    check_eq("dis_no_tick0", n_t, 0);
    check_eq("dis_ch2_seen", (t2n > 0) ? 1 : 0, 1);
    check_eq("dis_ch2_phase", (t2n - t2) % 20, 0);

    // asynchronous reset mid-operation
    t_a = -1;
    for (int k = 0; k < 20 && t_a < 0; k++) begin
      @(negedge clk);
      if (slowclk[1]) t_a = cyc;
    end
    check_eq("pre_rst_slow", (slowclk != 4'b0) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_tick", int'(tick), 0);
    check_eq("arst_slow", int'(slowclk), 0);
    check_eq("arst_ready", int'(cfg_if.ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    n_t = 0;
    repeat (60) begin
      @(negedge clk);
      if (tick != 4'b0 || slowclk != 4'b0) n_t++;
    end
    check_eq("post_rst_quiet", n_t, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
